// File: rtl/fp_pkg.sv
// Shared floating-point definitions: formats, rounding modes, unrounded
// result bundle, exception flags and special-value encodings.
package fp_pkg;

    typedef enum logic [1:0] {
        FP16 = 2'd0,
        FP32 = 2'd1,
        FP64 = 2'd2
    } fp_format_e;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } roundmode_e;

    function automatic int fp_width_of(input fp_format_e fmt);
        case (fmt)
            FP16:    return 32'sd16;
            FP32:    return 32'sd32;
            FP64:    return 32'sd64;
            default: return 32'sd32;
        endcase
    endfunction

    function automatic int exp_width_of(input fp_format_e fmt);
        case (fmt)
            FP16:    return 32'sd5;
            FP32:    return 32'sd8;
            FP64:    return 32'sd11;
            default: return 32'sd8;
        endcase
    endfunction

    function automatic int mant_width_of(input fp_format_e fmt);
        return fp_width_of(fmt) - exp_width_of(fmt) - 32'sd1;
    endfunction

    // Format the shared result bundle is sized for.
    localparam fp_format_e FP_FMT     = FP32;
    localparam int         FP_WIDTH   = fp_width_of(FP_FMT);
    localparam int         EXP_WIDTH  = exp_width_of(FP_FMT);
    localparam int         MANT_WIDTH = mant_width_of(FP_FMT);

    typedef struct packed {
        logic [FP_WIDTH-1:0] u_result;   // sign, biased exponent, truncated mantissa
        logic [1:0]          rs;         // {guard, sticky}
        logic                round_en;
        logic                invalid;
        logic [1:0]          exp_cout;   // exponent extension: bit1 = negative
    } uround_res_t;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fp_flags_t;

    localparam fp_flags_t FLAGS_NONE = '{nv: 1'b0, dz: 1'b0, of: 1'b0, uf: 1'b0, nx: 1'b0};

    // Default quiet NaN (negative, quiet bit set).
    localparam logic [FP_WIDTH-1:0] R_IND =
        {1'b1, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};

    function automatic logic [FP_WIDTH-1:0] fp_inf(input logic sign);
        return {sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    endfunction

    function automatic logic [FP_WIDTH-1:0] fp_max(input logic sign);
        return {sign, {(EXP_WIDTH-1){1'b1}}, 1'b0, {MANT_WIDTH{1'b1}}};
    endfunction

endpackage

// File: rtl/fp_rnd_incr.sv
// Round-up decision for one result: given mode, sign, mantissa LSB and the
// guard/sticky bits, says whether the truncated mantissa must be incremented.
module fp_rnd_incr
    import fp_pkg::*;
(
    input  roundmode_e mode_i,
    input  logic       sign_i,
    input  logic       lsb_i,
    input  logic       guard_i,
    input  logic       sticky_i,
    output logic       inc_o
);

    // Mode-dependent increment; directed modes look at the sign.
    always_comb begin
        inc_o = 1'b0;
        case (mode_i)
            RNE:     inc_o = guard_i & (sticky_i | lsb_i);
            RTZ:     inc_o = 1'b0;
            RDN:     inc_o = sign_i & (guard_i | sticky_i);
            RUP:     inc_o = ~sign_i & (guard_i | sticky_i);
            RMM:     inc_o = guard_i;
            default: inc_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_rnd_pipe.sv
// Two-stage rounding/packing pipeline. Stage 1 applies the rounding increment
// and extends the exponent; stage 2 resolves specials, overflow and underflow
// and holds the final encoding and flags as registered outputs.
module fp_rnd_pipe
    import fp_pkg::*;
#(
    parameter fp_format_e FP_FORMAT = FP32
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  uround_res_t         urnd_result_i,
    input  roundmode_e          rnd_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [FP_WIDTH-1:0] result_o,
    output fp_flags_t           flags_o
);

    localparam int FW = fp_width_of(FP_FORMAT);
    localparam int EW = exp_width_of(FP_FORMAT);
    localparam int MW = mant_width_of(FP_FORMAT);

    // Smallest biased exponent that no longer fits a finite number.
    localparam logic [EW+2:0] EXP_OVF = {3'b000, {EW{1'b1}}};

    // ---------------- stage 1 datapath ----------------
    logic          w_sign;
    logic [EW-1:0] w_exp;
    logic [MW-1:0] w_mant;
    logic          w_inc;
    logic          w_inc_en;
    logic [MW:0]   w_mant_sum;
    logic          w_zero;
    logic          w_s1_load;
    logic          w_s2_load;

    assign w_sign     = urnd_result_i.u_result[FW-1];
    assign w_exp      = urnd_result_i.u_result[FW-2:MW];
    assign w_mant     = urnd_result_i.u_result[MW-1:0];
    assign w_inc_en   = w_inc & urnd_result_i.round_en;
    assign w_mant_sum = {1'b0, w_mant} + {{MW{1'b0}}, w_inc_en};
    assign w_zero     = (w_exp == {EW{1'b0}}) && (w_mant == {MW{1'b0}}) &&
                        (urnd_result_i.rs == 2'b00) && (urnd_result_i.exp_cout == 2'b00);

    fp_rnd_incr u_rnd_incr (
        .mode_i   (rnd_i),
        .sign_i   (w_sign),
        .lsb_i    (w_mant[0]),
        .guard_i  (urnd_result_i.rs[1]),
        .sticky_i (urnd_result_i.rs[0]),
        .inc_o    (w_inc)
    );

    // ---------------- stage registers ----------------
    logic          r_s1_v;
    logic [FW-1:0] r_s1_u;
    logic [MW:0]   r_s1_mant;
    logic [EW+1:0] r_s1_ext_exp;
    logic          r_s1_nx;
    logic          r_s1_invalid;
    logic          r_s1_round_en;
    logic          r_s1_zero;
    roundmode_e    r_s1_rnd;

    logic          r_s2_v;
    logic [FW-1:0] r_res;
    fp_flags_t     r_flags;

    // Stage 2 frees up when empty or draining; stage 1 when empty or moving on.
    assign w_s2_load = ~r_s2_v | ready_i;
    assign w_s1_load = ~r_s1_v | w_s2_load;
    assign ready_o   = ~reset_i & w_s1_load;

    // ---------------- stage 2 datapath ----------------
    logic          w_s1_sign;
    logic [EW+2:0] w_exp_adj;
    logic          w_ovf;
    logic          w_unf;
    logic [FW-1:0] w_res;
    fp_flags_t     w_flags;

    assign w_s1_sign = r_s1_u[FW-1];
    // One extra bit so a carry into the exponent can never wrap its sign.
    assign w_exp_adj = {r_s1_ext_exp[EW+1], r_s1_ext_exp} + {{(EW+2){1'b0}}, r_s1_mant[MW]};
    assign w_ovf     = ~w_exp_adj[EW+2] && (w_exp_adj >= EXP_OVF);
    assign w_unf     = w_exp_adj[EW+2] || (w_exp_adj == {(EW+3){1'b0}}) || r_s1_ext_exp[EW+1];

    // Exception priority mux producing the final encoding and flags.
    always_comb begin
        w_res   = r_s1_u;
        w_flags = FLAGS_NONE;
        if (r_s1_invalid) begin
            w_res      = R_IND;
            w_flags.nv = 1'b1;
        end else if (!r_s1_round_en) begin
            w_res = r_s1_u;
        end else if (r_s1_zero) begin
            w_res = {w_s1_sign, {(FW-1){1'b0}}};
        end else if (w_ovf) begin
            w_flags.of = 1'b1;
            w_flags.nx = 1'b1;
            case (r_s1_rnd)
                RNE:     w_res = fp_inf(w_s1_sign);
                RMM:     w_res = fp_inf(w_s1_sign);
                RTZ:     w_res = fp_max(w_s1_sign);
                RDN:     w_res = w_s1_sign ? fp_inf(1'b1) : fp_max(1'b0);
                RUP:     w_res = w_s1_sign ? fp_max(1'b1) : fp_inf(1'b0);
                default: w_res = fp_inf(w_s1_sign);
            endcase
        end else if (w_unf) begin
            // No subnormal outputs: anything too small flushes to signed zero.
            w_res      = {w_s1_sign, {(FW-1){1'b0}}};
            w_flags.uf = 1'b1;
            w_flags.nx = 1'b1;
        end else begin
            w_res      = {w_s1_sign, w_exp_adj[EW-1:0], r_s1_mant[MW-1:0]};
            w_flags.nx = r_s1_nx;
        end
    end

    // Pipeline registers: stage 1 captures accepted inputs, stage 2 the resolved result.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_s1_v        <= 1'b0;
            r_s1_u        <= {FW{1'b0}};
            r_s1_mant     <= {(MW+1){1'b0}};
            r_s1_ext_exp  <= {(EW+2){1'b0}};
            r_s1_nx       <= 1'b0;
            r_s1_invalid  <= 1'b0;
            r_s1_round_en <= 1'b0;
            r_s1_zero     <= 1'b0;
            r_s1_rnd      <= RNE;
            r_s2_v        <= 1'b0;
            r_res         <= {FW{1'b0}};
            r_flags       <= FLAGS_NONE;
        end else begin
            if (w_s2_load) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_res   <= w_res;
                    r_flags <= w_flags;
                end
            end
            if (w_s1_load) begin
                r_s1_v <= valid_i;
                if (valid_i) begin
                    r_s1_u        <= urnd_result_i.u_result;
                    r_s1_mant     <= w_mant_sum;
                    r_s1_ext_exp  <= {urnd_result_i.exp_cout, w_exp};
                    r_s1_nx       <= urnd_result_i.round_en & (urnd_result_i.rs[1] | urnd_result_i.rs[0]);
                    r_s1_invalid  <= urnd_result_i.invalid;
                    r_s1_round_en <= urnd_result_i.round_en;
                    r_s1_zero     <= w_zero;
                    r_s1_rnd      <= rnd_i;
                end
            end
        end
    end

    assign valid_o  = r_s2_v;
    assign result_o = r_res;
    assign flags_o  = r_flags;

endmodule

// File: tb/tb_fp_rnd_pipe.sv
// Self-checking bench for fp_rnd_pipe: directed corner cases, stall and reset
// scenarios, then randomized traffic against an arithmetic reference model.
module tb_fp_rnd_pipe;
    import fp_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flags;
        int          t;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        valid_i;
    logic        ready_o;
    uround_res_t urnd_result_i;
    roundmode_e  rnd_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    fp_flags_t   flags_o;

    fp_rnd_pipe #(.FP_FORMAT(FP32)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .urnd_result_i (urnd_result_i),
        .rnd_i         (rnd_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .result_o      (result_o),
        .flags_o       (flags_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    exp_t        q[$];
    bit          prev_stall = 1'b0;
    logic [31:0] prev_res;
    logic [4:0]  prev_flags;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic uround_res_t mk(input logic [31:0] u, input logic [1:0] rs,
                                       input logic en, input logic inv, input logic [1:0] ec);
        uround_res_t d;
        d.u_result = u;
        d.rs       = rs;
        d.round_en = en;
        d.invalid  = inv;
        d.exp_cout = ec;
        return d;
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] res, input logic [4:0] flags);
        exp_t e;
        e.res   = res;
        e.flags = flags;
        e.t     = 0;
        return e;
    endfunction

    // Reference: plain integer arithmetic on sign / exponent / mantissa.
    function automatic exp_t ref_model(input uround_res_t d, input roundmode_e m);
        exp_t r;
        bit   sgn = d.u_result[31];
        int   e   = int'(d.u_result[30:23]);
        int   mt  = int'(d.u_result[22:0]);
        bit   g   = d.rs[1];
        bit   s   = d.rs[0];
        int   inc = 0;
        int   big_e;
        bit   to_inf;
        r.t = 0;
        if (d.invalid) return mk_exp(32'hFFC0_0000, 5'b10000);
        if (!d.round_en) return mk_exp(d.u_result, 5'b00000);
        if (e == 0 && mt == 0 && d.rs == 2'b00 && d.exp_cout == 2'b00)
            return mk_exp({sgn, 31'h0}, 5'b00000);
        case (m)
            RNE: inc = (g && (s || (mt % 2 == 1))) ? 1 : 0;
            RTZ: inc = 0;
            RDN: inc = (sgn && (g || s)) ? 1 : 0;
            RUP: inc = (!sgn && (g || s)) ? 1 : 0;
            RMM: inc = g ? 1 : 0;
            default: inc = 0;
        endcase
        mt    = mt + inc;
        big_e = e + 256 * int'(d.exp_cout[0]) - 512 * int'(d.exp_cout[1]);
        if (mt == (1 << 23)) begin
            mt    = 0;
            big_e = big_e + 1;
        end
        if (big_e >= 255) begin
            to_inf = (m == RNE) || (m == RMM) || (m == RUP && !sgn) || (m == RDN && sgn);
            r = mk_exp(to_inf ? {sgn, 8'hFF, 23'h0} : {sgn, 8'hFE, 23'h7FFFFF}, 5'b00101);
        end else if (big_e <= 0 || d.exp_cout[1]) begin
            r = mk_exp({sgn, 31'h0}, 5'b00011);
        end else begin
            r = mk_exp({sgn, 8'(big_e), 23'(mt)}, {4'b0000, (g || s)});
        end
        return r;
    endfunction

    // One clock cycle: drive, check at the falling edge, track transfers.
    task automatic step(input logic v, input uround_res_t d, input roundmode_e m, input logic rdy,
                        input logic use_model, input exp_t e_in, output logic acc);
        exp_t e;
        exp_t got;
        valid_i       = v;
        urnd_result_i = d;
        rnd_i         = m;
        ready_i       = rdy;
        @(negedge clk_i);
        check_eq("ready_o", 64'(ready_o), 64'((q.size() < 2) || rdy));
        check_eq("valid_o", 64'(valid_o), 64'((q.size() > 0) && (cyc >= q[0].t + 2)));
        if (prev_stall) begin
            check_eq("hold_valid", 64'(valid_o), 64'(1'b1));
            check_eq("hold_result", 64'(result_o), 64'(prev_res));
            check_eq("hold_flags", 64'(flags_o), 64'(prev_flags));
        end
        if (valid_o && rdy) begin
            if (q.size() == 0) begin
                check_eq("spurious_out", 64'(1'b1), 64'(1'b0));
            end else begin
                got = q.pop_front();
                check_eq("result", 64'(result_o), 64'(got.res));
                check_eq("flags", 64'(flags_o), 64'(got.flags));
            end
        end
        prev_stall = valid_o && !rdy;
        prev_res   = result_o;
        prev_flags = flags_o;
        acc = v && ready_o;
        if (acc) begin
            e   = use_model ? ref_model(d, m) : e_in;
            e.t = cyc;
            q.push_back(e);
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    uround_res_t dir_d[8];
    roundmode_e  dir_m[8];
    exp_t        dir_e[8];

    initial begin
        logic        acc;
        int          idx;
        uround_res_t d;
        logic [31:0] u;
        logic [7:0]  ex;
        int          sel;
        exp_t        dummy;

        dummy         = mk_exp(32'h0, 5'b0);
        reset_i       = 1'b1;
        valid_i       = 1'b0;
        ready_i       = 1'b0;
        rnd_i         = RNE;
        urnd_result_i = mk(32'h0, 2'b00, 1'b0, 1'b0, 2'b00);
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("rst_valid_o", 64'(valid_o), 64'(1'b0));
        check_eq("rst_result_o", 64'(result_o), 64'(32'h0));
        check_eq("rst_flags_o", 64'(flags_o), 64'(5'b0));
        check_eq("rst_ready_o", 64'(ready_o), 64'(1'b0));
        reset_i = 1'b0;
        #1;
        check_eq("post_rst_ready_o", 64'(ready_o), 64'(1'b1));

        // Directed corner cases with hand-derived expectations.
        dir_d[0] = mk(32'h3F80_0000, 2'b10, 1'b1, 1'b0, 2'b00); dir_m[0] = RNE; dir_e[0] = mk_exp(32'h3F80_0000, 5'b00001);
        dir_d[1] = mk(32'h3FFF_FFFF, 2'b11, 1'b1, 1'b0, 2'b00); dir_m[1] = RNE; dir_e[1] = mk_exp(32'h4000_0000, 5'b00001);
        dir_d[2] = mk(32'h7F7F_FFFF, 2'b10, 1'b1, 1'b0, 2'b00); dir_m[2] = RUP; dir_e[2] = mk_exp(32'h7F80_0000, 5'b00101);
        dir_d[3] = mk(32'h7F7F_FFFF, 2'b10, 1'b1, 1'b0, 2'b00); dir_m[3] = RTZ; dir_e[3] = mk_exp(32'h7F7F_FFFF, 5'b00001);
        dir_d[4] = mk(32'h1234_5678, 2'b11, 1'b1, 1'b1, 2'b01); dir_m[4] = RNE; dir_e[4] = mk_exp(32'hFFC0_0000, 5'b10000);
        dir_d[5] = mk(32'h1234_5678, 2'b11, 1'b0, 1'b0, 2'b00); dir_m[5] = RUP; dir_e[5] = mk_exp(32'h1234_5678, 5'b00000);
        dir_d[6] = mk(32'h8080_0000, 2'b01, 1'b1, 1'b0, 2'b11); dir_m[6] = RNE; dir_e[6] = mk_exp(32'h8000_0000, 5'b00011);
        dir_d[7] = mk(32'hFF7F_FFFF, 2'b01, 1'b1, 1'b0, 2'b00); dir_m[7] = RDN; dir_e[7] = mk_exp(32'hFF80_0000, 5'b00101);
        for (int i = 0; i < 8; i++) step(1'b1, dir_d[i], dir_m[i], 1'b1, 1'b0, dir_e[i], acc);
        for (int i = 0; i < 4; i++) step(1'b0, dir_d[0], RNE, 1'b1, 1'b0, dummy, acc);
        check_eq("directed_drain", 64'(q.size()), 64'(0));

        // Three back-to-back inputs with the consumer stalled for several cycles.
        idx = 0;
        for (int k = 0; k < 30; k++) begin
            if (idx >= 3 && q.size() == 0) break;
            step(idx < 3, dir_d[idx % 3], RNE, !(k >= 1 && k <= 4), 1'b0, dir_e[idx % 3], acc);
            if (acc) idx++;
        end
        check_eq("stall_all_in", 64'(idx), 64'(3));
        check_eq("stall_drain", 64'(q.size()), 64'(0));

        // Reset with both stages occupied drops everything.
        step(1'b1, dir_d[1], RNE, 1'b0, 1'b0, dir_e[1], acc);
        step(1'b1, dir_d[2], RUP, 1'b0, 1'b0, dir_e[2], acc);
        check_eq("full_valid_o", 64'(valid_o), 64'(1'b1));
        reset_i = 1'b1;
        valid_i = 1'b1;
        ready_i = 1'b1;
        @(negedge clk_i);
        check_eq("rst_mid_ready_o", 64'(ready_o), 64'(1'b0));
        @(posedge clk_i);
        #1;
        cyc++;
        check_eq("rst_mid_valid_o", 64'(valid_o), 64'(1'b0));
        check_eq("rst_mid_result_o", 64'(result_o), 64'(32'h0));
        check_eq("rst_mid_flags_o", 64'(flags_o), 64'(5'b0));
        q.delete();
        prev_stall = 1'b0;
        reset_i    = 1'b0;
        valid_i    = 1'b0;
        ready_i    = 1'b0;
        #1;
        check_eq("rst_mid_ready_after", 64'(ready_o), 64'(1'b1));
        for (int i = 0; i < 3; i++) step(1'b0, dir_d[0], RNE, 1'b1, 1'b0, dummy, acc);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            sel = int'($urandom_range(3, 0));
            ex  = (sel == 0) ? 8'($urandom_range(2, 0)) :
                  (sel == 1) ? 8'($urandom_range(255, 252)) : 8'($urandom_range(255, 0));
            u   = {1'($urandom_range(1, 0)), ex,
                   ($urandom_range(3, 0) == 0) ? 23'h7FFFFF : 23'($urandom)};
            if ($urandom_range(15, 0) == 0) u[22:0] = 23'h0;
            sel = int'($urandom_range(7, 0));
            d = mk(u, 2'($urandom_range(3, 0)), $urandom_range(9, 0) != 0,
                   $urandom_range(19, 0) == 0,
                   (sel < 5) ? 2'b00 : (sel == 5) ? 2'b01 : (sel == 6) ? 2'b11 : 2'b10);
            step($urandom_range(9, 0) < 7, d, roundmode_e'($urandom_range(4, 0)),
                 $urandom_range(9, 0) < 6, 1'b1, dummy, acc);
        end
        for (int i = 0; i < 10; i++) step(1'b0, d, RNE, 1'b1, 1'b0, dummy, acc);
        check_eq("final_drain", 64'(q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
